mc_ctrl: RTL

Multicycle control FSM for the MIPS datapath. It sequences instruction fetch, decode, execute, memory access and writeback over several clocks using a shared ALU and a single unified memory port. It replaces the single-cycle decoder and drives the same control fields: RegWrite, MemWrite, EXTOp, ALUOp, NPCOp, GPRSel, WDSel and AregSel. It adds the multicycle strobes PCWrite, IRWrite and IorD, plus a memory request/ready handshake.

---
 rtl/mc_ctrl_defs.sv | 87 ++++++++
 rtl/mc_decode.sv | 59 +++++
 rtl/mc_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_defs.sv
// Shared encodings for the multicycle MIPS control path: FSM states, ALU/NPC
// operation codes, register-file write selects and the decoded instruction class.
package mc_ctrl_defs;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLLV = 4'd9;
  localparam logic [3:0] ALU_SRLV = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JUMPR  = 2'b11;

  localparam logic [1:0] GPR_RD  = 2'b00;
  localparam logic [1:0] GPR_RT  = 2'b01;
  localparam logic [1:0] GPR_R31 = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    logic       rtype_alu;
    logic       shift_imm;
    logic       itype_alu;
    logic       load;
    logic       store;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic       illegal;
    logic [3:0] alu_op;
    logic       ext_op;
    logic       areg_sel;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct to class flags plus
// the ALU operation, extension mode and shamt select used during EXEC.
module mc_decode
  import mc_ctrl_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_SUB;  end
          FN_AND:          begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_AND;  end
          FN_OR:           begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_OR;   end
          FN_NOR:          begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_NOR;  end
          FN_SLT:          begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_SLT;  end
          FN_SLTU:         begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_SLTU; end
          FN_SLLV:         begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_SLLV; end
          FN_SRLV:         begin dec.rtype_alu = 1'b1; dec.alu_op = ALU_SRLV; end
          FN_SLL: begin
            dec.shift_imm = 1'b1;
            dec.areg_sel  = 1'b1;
            dec.alu_op    = ALU_SLL;
          end
          FN_SRL: begin
            dec.shift_imm = 1'b1;
            dec.areg_sel  = 1'b1;
            dec.alu_op    = ALU_SRL;
          end
          FN_JR:   dec.jump_reg = 1'b1;
          FN_JALR: begin dec.jump_reg = 1'b1; dec.link = 1'b1; end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_J:   dec.jump = 1'b1;
      OP_JAL: begin dec.jump = 1'b1; dec.link = 1'b1; end
      OP_BEQ: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
      OP_BNE: begin
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
        dec.alu_op    = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin dec.itype_alu = 1'b1; dec.alu_op = ALU_ADD; dec.ext_op = 1'b1; end
      OP_SLTI:           begin dec.itype_alu = 1'b1; dec.alu_op = ALU_SLT; dec.ext_op = 1'b1; end
      OP_LUI:            begin dec.itype_alu = 1'b1; dec.alu_op = ALU_LUI; dec.ext_op = 1'b1; end
      OP_ANDI:           begin dec.itype_alu = 1'b1; dec.alu_op = ALU_AND; end
      OP_ORI:            begin dec.itype_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OP_LW:             begin dec.load  = 1'b1; dec.alu_op = ALU_ADD; dec.ext_op = 1'b1; end
      OP_SW:             begin dec.store = 1'b1; dec.alu_op = ALU_ADD; dec.ext_op = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with a unified memory
// request handshake and a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       NPCOp,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             EXTOp,
  output logic             ALUSrcB,
  output logic             AregSel,
  output logic [3:0]       ALUOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t state_q, state_d;
  dec_t   dec;
  logic   retire;

  mc_decode u_decode (
    .op    (Op),
    .funct (Funct),
    .dec   (dec)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign state = state_q;

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = NPC_PLUS4;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrcB  = 1'b0;
    AregSel  = 1'b0;
    ALUOp    = ALU_NOP;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.illegal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (dec.jump || dec.jump_reg) begin
          // PC already advanced in FETCH, so the link value is the current PC.
          PCWrite = 1'b1;
          NPCOp   = dec.jump ? NPC_JUMP : NPC_JUMPR;
          if (dec.link) begin
            RegWrite = 1'b1;
            GPRSel   = GPR_R31;
            WDSel    = WD_PC;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUOp   = dec.alu_op;
        ALUSrcB = dec.itype_alu | dec.load | dec.store;
        AregSel = dec.areg_sel;
        EXTOp   = dec.ext_op;
        if (dec.branch) begin
          PCWrite = dec.branch_ne ? ~Zero : Zero;
          NPCOp   = NPC_BRANCH;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (dec.load || dec.store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = dec.store;
        if (mem_ready) begin
          if (dec.store) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        GPRSel   = (dec.rtype_alu | dec.shift_imm) ? GPR_RD : GPR_RT;
        WDSel    = dec.load ? WD_MEM : WD_ALU;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // During reset the memory port keeps requesting the fetch address but
    // mem_ready must not be able to trigger any write strobe.
    if (!rstn) begin
      retire   = 1'b0;
      mem_req  = 1'b1;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      NPCOp    = NPC_PLUS4;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrcB  = 1'b0;
      AregSel  = 1'b0;
      ALUOp    = ALU_NOP;
      GPRSel   = GPR_RD;
      WDSel    = WD_ALU;
      illegal  = 1'b0;
    end
  end

endmodule
